// File: rtl/nios_system_shared_mem_pkg.sv
// Shared constants and types for the multi-port shared on-chip memory.
package nios_system_shared_mem_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 13;
  localparam int DEF_DEPTH     = 8192;
  localparam     DEF_INIT_FILE = "nios_system_shared_onchip_memory.hex";

  localparam int MAX_PORTS     = 8;
  localparam int PORT_IDX_W    = 3;
  localparam int RD_LAT_BASE   = 1;
  localparam int RD_LAT_OUTREG = 2;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // Next port index in round-robin order, wrapping at num_ports.
  function automatic port_idx_t rr_next(input port_idx_t idx, input int num_ports);
    return (idx == port_idx_t'(num_ports - 1)) ? '0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/nios_system_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the
// granted port whenever a grant is issued.
module nios_system_rr_arbiter
  import nios_system_shared_mem_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output port_idx_t            grant_idx,
  output logic                 grant_vld
);

  port_idx_t            ptr_r;
  port_idx_t            cand_s;
  logic                 hit_s;
  logic [MAX_PORTS-1:0] req_pad_s;

  // Search from the pointer for the first requester.
  always_comb begin
    req_pad_s                 = '0;
    req_pad_s[NUM_PORTS-1:0]  = req;
    grant_vld                 = 1'b0;
    grant_idx                 = '0;
    hit_s                     = 1'b0;
    cand_s                    = ptr_r;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit_s     = en & ~grant_vld & req_pad_s[cand_s];
      grant_idx = hit_s ? cand_s : grant_idx;
      grant_vld = grant_vld | hit_s;
      cand_s    = rr_next(cand_s, NUM_PORTS);
    end
  end

  // One-hot grant decode.
  always_comb begin
    grant = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      grant[j] = grant_vld & (grant_idx == port_idx_t'(j));
    end
  end

  // Priority pointer: port after the last grant gets first look next time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else if (grant_vld) begin
      ptr_r <= rr_next(grant_idx, NUM_PORTS);
    end
  end

endmodule

// File: rtl/nios_system_shared_onchip_memory.sv
// Multi-port Avalon-MM shared on-chip RAM with round-robin access.
// Define SHARED_ONCHIP_MEMORY_OUTREG_EN to add a RAM output register (latency 2).
module nios_system_shared_onchip_memory
  import nios_system_shared_mem_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter     INIT_FILE = DEF_INIT_FILE
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clken,
  input  logic [NUM_PORTS-1:0]          chipselect,
  input  logic [NUM_PORTS-1:0]          read,
  input  logic [NUM_PORTS-1:0]          write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   address,
  input  logic [NUM_PORTS*DATA_W/8-1:0] byteenable,
  input  logic [NUM_PORTS*DATA_W-1:0]   writedata,
  output logic [NUM_PORTS-1:0]          waitrequest,
  output logic [NUM_PORTS*DATA_W-1:0]   readdata,
  output logic [NUM_PORTS-1:0]          readdatavalid
);

  localparam int              BE_W      = DATA_W / 8;
  localparam int              RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
`ifdef SHARED_ONCHIP_MEMORY_OUTREG_EN
  localparam int              RD_LATENCY = RD_LAT_OUTREG;
`else
  localparam int              RD_LATENCY = RD_LAT_BASE;
`endif

  logic [NUM_PORTS-1:0] req_s;
  logic [NUM_PORTS-1:0] grant_s;
  port_idx_t            grant_idx_s;
  logic                 grant_vld_s;
  logic                 arb_en_s;

  logic [ADDR_W-1:0]    addr_s;
  logic [RAM_AW-1:0]    ram_addr_s;
  logic [BE_W-1:0]      be_s;
  logic [DATA_W-1:0]    wdata_s;
  logic                 is_write_s;
  logic                 in_range_s;
  logic                 ram_we_s;
  logic                 ram_re_s;

  logic [DATA_W-1:0]    mem [0:DEPTH-1];
  logic [DATA_W-1:0]    ram_q_r;

  logic                 s1_vld_r;
  logic                 s1_oor_r;
  port_idx_t            s1_port_r;
  logic [DATA_W-1:0]    s1_data_s;

  logic                 fin_vld_s;
  port_idx_t            fin_port_s;
  logic [DATA_W-1:0]    fin_data_s;

  logic [NUM_PORTS-1:0] rdv_s;
  logic [DATA_W-1:0]    hold_r [NUM_PORTS];

  // Reset also blocks grants so nothing is accepted while it is held low.
  assign arb_en_s    = clken & reset_n;
  assign req_s       = chipselect & (read | write);
  assign waitrequest = ~grant_s;

  nios_system_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (arb_en_s),
    .req       (req_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_vld (grant_vld_s)
  );

  // AND-OR mux of the granted port's request fields; write wins over read.
  always_comb begin
    addr_s     = '0;
    be_s       = '0;
    wdata_s    = '0;
    is_write_s = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_s     = addr_s  | ({ADDR_W{grant_s[p]}} & address[p*ADDR_W +: ADDR_W]);
      be_s       = be_s    | ({BE_W{grant_s[p]}}   & byteenable[p*BE_W +: BE_W]);
      wdata_s    = wdata_s | ({DATA_W{grant_s[p]}} & writedata[p*DATA_W +: DATA_W]);
      is_write_s = is_write_s | (grant_s[p] & write[p]);
    end
  end

  assign in_range_s = ({1'b0, addr_s} < DEPTH_LIM);
  assign ram_addr_s = addr_s[RAM_AW-1:0];
  assign ram_we_s   = grant_vld_s & is_write_s & in_range_s;
  assign ram_re_s   = grant_vld_s & ~is_write_s & in_range_s;

  // Single-port byte-enabled RAM; deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_s[b]) begin
          mem[ram_addr_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
        end
      end
    end
    if (ram_re_s) begin
      ram_q_r <= mem[ram_addr_s];
    end
  end

  // First read stage; holds while clken is low so a stalled read is not lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld_r  <= 1'b0;
      s1_oor_r  <= 1'b0;
      s1_port_r <= '0;
    end else if (clken) begin
      s1_vld_r  <= grant_vld_s & ~is_write_s;
      s1_oor_r  <= ~in_range_s;
      s1_port_r <= grant_idx_s;
    end
  end

  assign s1_data_s = s1_oor_r ? '0 : ram_q_r;

  if (RD_LATENCY == RD_LAT_OUTREG) begin : g_outreg
    logic              s2_vld_r;
    port_idx_t         s2_port_r;
    logic [DATA_W-1:0] s2_data_r;

    // RAM output register stage.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        s2_vld_r  <= 1'b0;
        s2_port_r <= '0;
        s2_data_r <= '0;
      end else if (clken) begin
        s2_vld_r  <= s1_vld_r;
        s2_port_r <= s1_port_r;
        s2_data_r <= s1_data_s;
      end
    end

    assign fin_vld_s  = s2_vld_r;
    assign fin_port_s = s2_port_r;
    assign fin_data_s = s2_data_r;
  end else begin : g_direct
    assign fin_vld_s  = s1_vld_r;
    assign fin_port_s = s1_port_r;
    assign fin_data_s = s1_data_s;
  end

  // A pending pulse only leaves when the pipeline actually advances.
  always_comb begin
    rdv_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rdv_s[p] = clken & reset_n & fin_vld_s & (fin_port_s == port_idx_t'(p));
    end
  end

  assign readdatavalid = rdv_s;

  // Per-port readdata: live word on the valid cycle, otherwise the last one.
  always_comb begin
    readdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      readdata[p*DATA_W +: DATA_W] = rdv_s[p] ? fin_data_s : hold_r[p];
    end
  end

  // Capture each port's delivered word so it persists between pulses.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!reset_n) begin
        hold_r[p] <= '0;
      end else if (rdv_s[p]) begin
        hold_r[p] <= fin_data_s;
      end
    end
  end

endmodule

// File: tb/tb_nios_system_shared_onchip_memory.sv
// Directed self-checking bench for nios_system_shared_onchip_memory (DEPTH 6000).
module tb_nios_system_shared_onchip_memory;

  localparam int NP    = 4;
  localparam int DW    = 32;
  localparam int AW    = 13;
  localparam int DEPTH = 6000;
`ifdef SHARED_ONCHIP_MEMORY_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               clk;
  logic               reset_n;
  logic               clken;
  logic [NP-1:0]      chipselect;
  logic [NP-1:0]      read;
  logic [NP-1:0]      write;
  logic [NP*AW-1:0]   address;
  logic [NP*DW/8-1:0] byteenable;
  logic [NP*DW-1:0]   writedata;
  logic [NP-1:0]      waitrequest;
  logic [NP*DW-1:0]   readdata;
  logic [NP-1:0]      readdatavalid;

  int checks   = 0;
  int failures = 0;

  nios_system_shared_onchip_memory #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DEPTH     (DEPTH),
    .INIT_FILE ("")
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clken         (clken),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .address       (address),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] w4(input logic [3:0] v);
    return {28'd0, v};
  endfunction

  function automatic logic [3:0] onehot(input int p);
    logic [3:0] m;
    m = 4'b0001 << p;
    return m;
  endfunction

  function automatic logic [31:0] rdata(input int p);
    return readdata[p*DW +: DW];
  endfunction

  task automatic clear_all();
    chipselect = '0;
    read       = '0;
    write      = '0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    chipselect[p]          = 1'b1;
    read[p]                = r;
    write[p]               = w;
    address[p*AW +: AW]    = a;
    byteenable[p*4 +: 4]   = be;
    writedata[p*DW +: DW]  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_write(input int p, input logic [AW-1:0] a, input logic [3:0] be,
                          input logic [31:0] d, input string tag);
    step();
    clear_all();
    set_port(p, 1'b0, 1'b1, a, be, d);
    sample();
    chk({tag, "_wait"}, w4(waitrequest), w4(~onehot(p)));
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] a, input logic [31:0] exp,
                         input string tag);
    step();
    clear_all();
    set_port(p, 1'b1, 1'b0, a, 4'hF, 32'h0);
    sample();
    chk({tag, "_wait"}, w4(waitrequest), w4(~onehot(p)));
    for (int i = 0; i < LAT; i++) begin
      step();
      clear_all();
    end
    sample();
    chk({tag, "_rdv"}, w4(readdatavalid), w4(onehot(p)));
    chk({tag, "_data"}, rdata(p), exp);
    step();
    sample();
    chk({tag, "_rdv_off"}, w4(readdatavalid), 32'd0);
    chk({tag, "_hold"}, rdata(p), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    clken   = 1'b1;
    clear_all();
    step();
    step();
    sample();
    chk("rst_wait",  w4(waitrequest),   32'h0000_000F);
    chk("rst_rdv",   w4(readdatavalid), 32'd0);
    chk("rst_data0", rdata(0),          32'd0);
    chk("rst_data3", rdata(3),          32'd0);
    step();
    reset_n = 1'b1;

    // All ports requesting: strict 0,1,2,3,0,1 rotation.
    for (int i = 0; i < 6; i++) begin
      step();
      clear_all();
      for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, 13'd0, 4'hF, 32'h0);
      sample();
      chk("rr_order", w4(waitrequest), w4(~onehot(i % 4)));
    end
    step();
    clear_all();
    step();
    step();

    // Write on port 0 then read back on port 2 in the very next cycle.
    do_write(0, 13'd5, 4'hF, 32'hDEAD_BEEF, "w5");
    do_read(2, 13'd5, 32'hDEAD_BEEF, "r5_p2");

    // Byte enables: partial and all-zero.
    do_write(1, 13'd9, 4'hF,    32'hFFFF_FFFF, "w9_full");
    do_write(3, 13'd9, 4'b0101, 32'h1122_3344, "w9_be");
    do_read(1, 13'd9, 32'hFF22_FF44, "be_mix");
    do_write(2, 13'd9, 4'b0000, 32'h0000_0000, "be_zero");
    do_read(3, 13'd9, 32'hFF22_FF44, "be_zero_rd");

    // Address range edges.
    do_write(1, 13'd5999, 4'hF, 32'h5A5A_A5A5, "w_last");
    do_read(1, 13'd5999, 32'h5A5A_A5A5, "r_last");
    do_write(3, 13'd7000, 4'hF, 32'hCAFE_F00D, "oor_w");
    do_read(2, 13'd8191, 32'h0000_0000, "oor_r8191");
    do_read(2, 13'd7000, 32'h0000_0000, "oor_r7000");
    do_read(0, 13'd5, 32'hDEAD_BEEF, "oor_keep");

    // clken stall right after a read grant.
    step();
    clear_all();
    set_port(1, 1'b1, 1'b0, 13'd5, 4'hF, 32'h0);
    sample();
    chk("stall_grant", w4(waitrequest), 32'h0000_000D);
    for (int i = 0; i < 3; i++) begin
      step();
      clear_all();
      clken = 1'b0;
      set_port(0, 1'b1, 1'b0, 13'd9, 4'hF, 32'h0);
      sample();
      chk("stall_wait", w4(waitrequest),   32'h0000_000F);
      chk("stall_rdv",  w4(readdatavalid), 32'd0);
    end
    step();
    clear_all();
    clken = 1'b1;
    for (int i = 0; i < LAT - 1; i++) step();
    sample();
    chk("stall_rdv_out", w4(readdatavalid), 32'h0000_0002);
    chk("stall_data",    rdata(1),          32'hDEAD_BEEF);
    step();
    sample();
    chk("stall_rdv_once", w4(readdatavalid), 32'd0);
    step();
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, 13'd9, 4'hF, 32'h0);
    sample();
    chk("stall_ptr", w4(waitrequest), 32'h0000_000B);
    step();
    clear_all();
    step();
    step();

    // Reset with a read in flight.
    step();
    clear_all();
    set_port(1, 1'b1, 1'b0, 13'd9, 4'hF, 32'h0);
    sample();
    chk("rif_grant", w4(waitrequest), 32'h0000_000D);
    step();
    clear_all();
    reset_n = 1'b0;
    sample();
    chk("rif_rdv",  w4(readdatavalid), 32'd0);
    chk("rif_wait", w4(waitrequest),   32'h0000_000F);
    step();
    reset_n = 1'b1;
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, 13'd9, 4'hF, 32'h0);
    sample();
    chk("rif_ptr",      w4(waitrequest),   32'h0000_000E);
    chk("rif_no_late",  w4(readdatavalid), 32'd0);
    chk("rif_hold_clr", rdata(1),          32'd0);
    for (int i = 0; i < LAT; i++) begin
      step();
      clear_all();
    end
    sample();
    chk("rif_keep_rdv",  w4(readdatavalid), 32'h0000_0001);
    chk("rif_keep_data", rdata(0),          32'hFF22_FF44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
